stream_rr_arbiter: RTL

- Shares one registered valid/ready output stage between NUM_REQ byte-stream requesters.
- Uses round-robin arbitration with packet locking: once granted, a requester keeps the stage until it sends a beat with last=1.
- Sits in front of downstream consumers that expect a single stream tagged with its source index.

---
 rtl/stream_pkg.sv | 41 ++++
 rtl/rr_priority_pick.sv | 36 +++
 rtl/stream_rr_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and round-robin pick helper for stream arbiters
package stream_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int MAX_REQ        = 8;
    localparam int MAX_SRC_W      = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_SRC_W-1:0] idx;
        logic [MAX_REQ-1:0]   grant;
    } pick_t;

    // First set bit of valid, scanning ptr, ptr+1, ... modulo num_req.
    // Sized for the largest supported arbiter; callers zero-extend.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                      input logic [MAX_SRC_W-1:0] ptr,
                                      input int                   num_req);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= num_req) begin
                j = j - num_req;
            end
            if ((k < num_req) && !r.found && valid[j[MAX_SRC_W-1:0]]) begin
                r.found                    = 1'b1;
                r.idx                      = j[MAX_SRC_W-1:0];
                r.grant[j[MAX_SRC_W-1:0]]  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate-and-priority-encode from valid vector and pointer
// Ports: valid (request vector), ptr (highest-priority index),
//        grant (one-hot), idx (granted index), found (any request present).
module rr_priority_pick
    import stream_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   idx,
    output logic               found
);

    logic [MAX_REQ-1:0]   valid_ext;
    logic [MAX_SRC_W-1:0] ptr_ext;
    pick_t                pick;
    logic                 unused_pick;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        ptr_ext                  = '0;
        ptr_ext[SRC_W-1:0]       = ptr;
        pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
        grant                    = pick.grant[NUM_REQ-1:0];
        idx                      = pick.idx[SRC_W-1:0];
        found                    = pick.found;
    end

    // Upper bits of the full-size pick are always zero for smaller arbiters.
    assign unused_pick = ^pick;

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin packet-locking arbiter onto one registered stream
// Ports: clk/rst (async active-low), in_data/in_valid/in_last/in_ready per requester,
//        out_data/out_last/out_src/out_valid registered output with out_ready backpressure,
//        locked high while a packet holds the stage.
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ-1:0]        in_last,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      locked
);

    arb_state_e          state_q, state_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [SRC_W-1:0]    lock_idx_q, lock_idx_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [SRC_W-1:0]    pick_idx;
    logic                pick_found;

    logic                stage_ready;
    logic [NUM_REQ-1:0]  grant;
    logic [SRC_W-1:0]    g_idx;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                accept;
    logic [SRC_W-1:0]    next_idx;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (in_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        stage_ready = ~out_valid_q | out_ready;

        // A locked packet owns the stage even while its requester is stalled.
        if (state_q == LOCKED) begin
            grant             = '0;
            grant[lock_idx_q] = 1'b1;
            g_idx             = lock_idx_q;
        end else begin
            grant             = pick_found ? pick_grant : '0;
            g_idx             = pick_idx;
        end

        in_ready = (rst && stage_ready) ? grant : '0;

        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g_idx == SRC_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*DATA_W +: DATA_W];
            end
        end

        accept   = sel_valid & (|in_ready);
        next_idx = (g_idx == SRC_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        // A new beat takes priority over draining, so there is no bubble.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = g_idx;
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = next_idx;
            end else begin
                state_d    = LOCKED;
                lock_idx_d = g_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign locked    = (state_q == LOCKED);

endmodule
